// File: rtl/mem_ctrl_pkg.sv
// Shared types for the main-memory controller: physical address, cacheline,
// queued request payload and the service FSM encoding.
package mem_ctrl_pkg;

   localparam int unsigned PADDR_W     = 32;
   localparam int unsigned LINE_W      = 128;
   localparam int unsigned MEM_LATENCY = 5;

   typedef logic [PADDR_W-1:0] pptr_t;
   typedef logic [LINE_W-1:0]  cacheline_t;

   typedef struct packed {
      pptr_t      addr;
      logic       wen;
      cacheline_t wline;
   } memreq_t;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_e;

   typedef enum logic {SRC_I, SRC_D} mem_src_e;

endpackage

// File: rtl/mem_ctrl_req_fifo.sv
// Request FIFO: a push against a full FIFO is discarded (no bypass through a same-cycle pop).
module mem_req_fifo #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  T                             din,
   input  logic                         pop,
   output T                             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   T               store [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
         if (push_ok && !pop_ok)
            count <= count + CW'(1);
         else if (pop_ok && !push_ok)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         store[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller: queues icache refills and dcache refills/writebacks,
// services one request at a time with fixed latency against an on-chip line array.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned LATENCY   = MEM_LATENCY,
   parameter int unsigned IQ_DEPTH  = 16,
   parameter int unsigned DQ_DEPTH  = 4,
   parameter int unsigned MEM_LINES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req_ren,
   input  pptr_t      i_req_addr,
   output logic       i_rec_en,
   output pptr_t      i_rec_addr,
   output cacheline_t i_rec_line,
   input  logic       d_req_ren,
   input  logic       d_req_wen,
   input  pptr_t      d_req_addr,
   input  cacheline_t d_req_wline,
   output logic       d_req_rdy,
   output logic       d_rec_en,
   output pptr_t      d_rec_addr,
   output cacheline_t d_rec_line,
   output logic       ovf_err
);

   localparam int unsigned IDX_W = $clog2(MEM_LINES);
   localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY-1) : 1;
   localparam int unsigned ICW   = $clog2(IQ_DEPTH+1);
   localparam int unsigned DCW   = $clog2(DQ_DEPTH+1);

   mem_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   memreq_t           cur_req;
   mem_src_e          cur_src;
   mem_src_e          rr_src;

   pptr_t             i_head;
   memreq_t           d_head;
   memreq_t           d_in;
   logic              i_full, i_empty, d_full, d_empty;
   logic [ICW-1:0]    i_count;
   logic [DCW-1:0]    d_count;
   logic              i_pop, d_pop, resp_go;
   logic              unused_cnt;

   cacheline_t        mem [MEM_LINES];
   logic [IDX_W-1:0]  idx;
   cacheline_t        rsp_line;

   assign d_in       = '{addr: d_req_addr, wen: d_req_wen, wline: d_req_wline};
   assign d_req_rdy  = !d_full;
   assign unused_cnt = ^{i_count, d_count};
   assign idx        = cur_req.addr[IDX_W+3:4];
   assign rsp_line   = cur_req.wen ? cur_req.wline : mem[idx];

   mem_req_fifo #(.T(pptr_t), .DEPTH(IQ_DEPTH)) u_iq (
      .clk(clk), .rst(rst), .push(i_req_ren), .din(i_req_addr), .pop(i_pop),
      .dout(i_head), .full(i_full), .empty(i_empty), .count(i_count)
   );

   mem_req_fifo #(.T(memreq_t), .DEPTH(DQ_DEPTH)) u_dq (
      .clk(clk), .rst(rst), .push(d_req_ren | d_req_wen), .din(d_in), .pop(d_pop),
      .dout(d_head), .full(d_full), .empty(d_empty), .count(d_count)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!i_empty || !d_empty) state_nxt = BUSY;
         BUSY:    if (cnt == '0)            state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Round-robin grant in IDLE; the response is launched on the last BUSY edge
   always_comb begin
      i_pop   = 1'b0;
      d_pop   = 1'b0;
      resp_go = (state == BUSY) && (cnt == '0);
      if (state == IDLE) begin
         if (!i_empty && (d_empty || rr_src == SRC_I)) i_pop = 1'b1;
         else if (!d_empty)                            d_pop = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         cur_req  <= '0;
         cur_src  <= SRC_I;
         rr_src   <= SRC_I;
         i_rec_en <= 1'b0;
         d_rec_en <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         i_rec_en <= resp_go && (cur_src == SRC_I);
         d_rec_en <= resp_go && (cur_src == SRC_D);
         if (i_req_ren && i_full)
            ovf_err <= 1'b1;
         if (i_pop) begin
            cur_req <= '{addr: i_head, wen: 1'b0, wline: '0};
            cur_src <= SRC_I;
            rr_src  <= SRC_D;
            cnt     <= CNT_W'(LATENCY-2);
         end else if (d_pop) begin
            cur_req <= d_head;
            cur_src <= SRC_D;
            rr_src  <= SRC_I;
            cnt     <= CNT_W'(LATENCY-2);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Response payload holds between pulses; a write is only committed outside reset
   always_ff @(posedge clk) begin
      if (resp_go && !rst) begin
         if (cur_src == SRC_I) begin
            i_rec_addr <= cur_req.addr;
            i_rec_line <= rsp_line;
         end else begin
            d_rec_addr <= cur_req.addr;
            d_rec_line <= rsp_line;
         end
         if (cur_req.wen)
            mem[idx] <= cur_req.wline;
      end
   end

endmodule
